// File: rtl/macc_pkg.sv
// Shared width helpers, elaboration width checks and the output round/saturate function
// for the multi-channel multiply-accumulator.
package macc_pkg;

    localparam int unsigned MaxW = 128;

    function automatic int unsigned prod_width(input int unsigned adw, input int unsigned bdw);
        return adw + bdw;
    endfunction

    function automatic int unsigned id_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic bit widths_ok(input int unsigned adw, input int unsigned bdw,
                                     input int unsigned aw, input int unsigned nch,
                                     input int unsigned oshift, input int unsigned odw);
        return (aw >= adw + bdw) && (aw <= MaxW) && (nch >= 1) && (odw >= 1) &&
               (odw + oshift <= aw);
    endfunction

    // Caller keeps the low odw bits; with sat_en clear that is a plain floor shift and wrap.
    function automatic logic signed [MaxW-1:0] scale_sum(input logic signed [MaxW-1:0] sum,
                                                         input int unsigned oshift,
                                                         input int unsigned odw,
                                                         input bit sat_en,
                                                         output logic clamped);
        logic signed [MaxW-1:0] v, one, hi, lo;
        one     = '0;
        one[0]  = 1'b1;
        v       = sum;
        clamped = 1'b0;
        if (sat_en && oshift > 0) v = v + (one <<< (oshift - 1));
        v = v >>> oshift;
        if (sat_en) begin
            hi = (one <<< (odw - 1)) - one;
            lo = -(one <<< (odw - 1));
            if (v > hi) begin
                v       = hi;
                clamped = 1'b1;
            end else if (v < lo) begin
                v       = lo;
                clamped = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/macc_multi_core.sv
// P1-P3 of the multi-channel MAC: operand register, product, per-channel accumulate.
// Beats with an out-of-range channel ID are dropped at P1.
module macc_multi_core
    import macc_pkg::*;
#(
    parameter int unsigned ADW = 24,
    parameter int unsigned BDW = 18,
    parameter int unsigned AW  = 48,
    parameter int unsigned NCH = 4,
    parameter int unsigned IDW = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic signed [ADW-1:0] in_a,
    input  logic signed [BDW-1:0] in_b,
    input  logic        [IDW-1:0] in_id,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic signed [AW-1:0]  out_sum,
    output logic        [IDW-1:0] out_id
);

    localparam int unsigned PW = prod_width(ADW, BDW);

    logic                  p1_valid_q, p1_last_q;
    logic signed [ADW-1:0] p1_a_q;
    logic signed [BDW-1:0] p1_b_q;
    logic        [IDW-1:0] p1_id_q;
    logic                  p2_valid_q, p2_last_q;
    logic signed [PW-1:0]  p2_prod_q;
    logic        [IDW-1:0] p2_id_q;
    logic                  out_valid_q;
    logic signed [AW-1:0]  out_sum_q;
    logic        [IDW-1:0] out_id_q;
    logic signed [AW-1:0]  acc_q [NCH];
    logic        [NCH-1:0] first_q;

    logic                  id_ok;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  base, sum;

    always_comb begin
        id_ok = 32'(in_id) < NCH;
        prod  = PW'(p1_a_q) * PW'(p1_b_q);
        base  = first_q[p2_id_q] ? '0 : acc_q[p2_id_q];
        sum   = base + AW'(p2_prod_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_valid_q  <= 1'b0;
            p2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            first_q     <= '1;
        end else if (ce) begin
            p1_valid_q  <= in_valid && id_ok;
            p2_valid_q  <= p1_valid_q;
            out_valid_q <= p2_valid_q && p2_last_q;
            if (p2_valid_q) first_q[p2_id_q] <= p2_last_q;
        end
    end

    // Accumulator read and write share P3, so consecutive beats on one channel see fresh data.
    always_ff @(posedge clk) begin
        if (ce) begin
            p1_a_q    <= in_a;
            p1_b_q    <= in_b;
            p1_id_q   <= in_id;
            p1_last_q <= in_last;
            p2_prod_q <= prod;
            p2_id_q   <= p1_id_q;
            p2_last_q <= p1_last_q;
            if (p2_valid_q && !p2_last_q) acc_q[p2_id_q] <= sum;
            out_sum_q <= sum;
            out_id_q  <= p2_id_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_id    = out_id_q;

endmodule

// File: rtl/macc_multi.sv
// Multi-channel AXI-stream multiply-accumulator: skid input stage, core, scaled output register.
// Define MACC_MULTI_SATURATE_EN for round-half-up and saturation with tuser clamp flag.
module macc_multi
    import macc_pkg::*;
#(
    parameter int unsigned ADW    = 24,
    parameter int unsigned BDW    = 18,
    parameter int unsigned AW     = 48,
    parameter int unsigned NCH    = 4,
    parameter int unsigned IDW    = id_width(NCH),
    parameter int unsigned OSHIFT = 24,
    parameter int unsigned ODW    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [ADW-1:0] s_axis_atdata,
    input  logic signed [BDW-1:0] s_axis_btdata,
    input  logic        [IDW-1:0] s_axis_tid,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic signed [ODW-1:0] m_axis_tdata,
    output logic        [IDW-1:0] m_axis_tid,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    if (!widths_ok(ADW, BDW, AW, NCH, OSHIFT, ODW)) begin : g_width_check
        $error("macc_multi: illegal ADW/BDW/AW/NCH/OSHIFT/ODW combination");
    end

`ifdef MACC_MULTI_SATURATE_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam int unsigned BW = ADW + BDW + IDW + 1;

    logic          ce, accept;
    logic [BW-1:0] in_beat;
    logic          ready_q, ready_d;
    logic          skid_valid_q, skid_valid_d, spare_valid_q, spare_valid_d;
    logic [BW-1:0] skid_data_q, skid_data_d, spare_data_q, spare_data_d;

    logic                  core_valid;
    logic signed [AW-1:0]  core_sum;
    logic        [IDW-1:0] core_id;

    logic signed [MaxW-1:0] scaled;
    logic                   clamped;
    logic                   unused_scaled;
    logic                   tvalid_q, tuser_q;
    logic signed [ODW-1:0]  tdata_q;
    logic        [IDW-1:0]  tid_q;

    assign ce      = !tvalid_q || m_axis_tready;
    assign accept  = s_axis_tvalid && ready_q;
    assign in_beat = {s_axis_atdata, s_axis_btdata, s_axis_tid, s_axis_tlast};

    // Two-slot skid: ready only depends on the spare slot, so it never sees m_axis_tready.
    always_comb begin
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        spare_valid_d = spare_valid_q;
        spare_data_d  = spare_data_q;
        if (ce) begin
            if (spare_valid_q) begin
                skid_valid_d  = 1'b1;
                skid_data_d   = spare_data_q;
                spare_valid_d = 1'b0;
            end else begin
                skid_valid_d = accept;
                skid_data_d  = in_beat;
            end
        end else if (accept) begin
            if (!skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_beat;
            end else begin
                spare_valid_d = 1'b1;
                spare_data_d  = in_beat;
            end
        end
        ready_d = !spare_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q       <= 1'b0;
            skid_valid_q  <= 1'b0;
            spare_valid_q <= 1'b0;
        end else begin
            ready_q       <= ready_d;
            skid_valid_q  <= skid_valid_d;
            spare_valid_q <= spare_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_data_q  <= skid_data_d;
        spare_data_q <= spare_data_d;
    end

    macc_multi_core #(
        .ADW(ADW),
        .BDW(BDW),
        .AW (AW),
        .NCH(NCH),
        .IDW(IDW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .in_valid (skid_valid_q),
        .in_a     (skid_data_q[BW-1 -: ADW]),
        .in_b     (skid_data_q[IDW+1 +: BDW]),
        .in_id    (skid_data_q[1 +: IDW]),
        .in_last  (skid_data_q[0]),
        .out_valid(core_valid),
        .out_sum  (core_sum),
        .out_id   (core_id)
    );

    always_comb begin
        clamped = 1'b0;
        scaled  = scale_sum(MaxW'(core_sum), OSHIFT, ODW, SatEn, clamped);
    end
    assign unused_scaled = ^scaled[MaxW-1:ODW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tid_q    <= '0;
            tuser_q  <= 1'b0;
        end else if (ce) begin
            tvalid_q <= core_valid;
            if (core_valid) begin
                tdata_q <= scaled[ODW-1:0];
                tid_q   <= core_id;
                tuser_q <= SatEn && clamped;
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: doc/macc_multi.md
# macc_multi

Multi-channel successor to the single-stream multiply-accumulator. It accepts an AXI-stream of signed (a, b) sample pairs tagged with a channel ID, and keeps one independent running sum per channel. When a beat with tlast arrives, it emits that channel's scaled frame sum and restarts the channel. It sits between interleaved-channel sources (e.g. polyphase or multi-tap FIR dataflows) and downstream stream consumers.

## Interface
- ADW, 24: width of signed operand A
- BDW, 18: width of signed operand B
- AW, 48: accumulator width; must be ≥ ADW+BDW (elaboration error otherwise)
- NCH, 4: number of channels, ≥1
- IDW, $clog2(NCH) (min 1): channel ID width
- OSHIFT, 24: arithmetic right shift applied to the frame sum at output
- ODW, 24: output width; must be ≤ AW−OSHIFT
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_axis_atdata  in  ADW  signed operand A
- s_axis_btdata  in  BDW  signed operand B
- s_axis_tid  in  IDW  channel of this beat
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- s_axis_tlast  in  1  last beat of this channel's frame
- m_axis_tdata  out  ODW  signed scaled frame sum
- m_axis_tid  out  IDW  channel the sum belongs to
- m_axis_tuser  out  1  saturation flag (0 when saturation is compiled out)
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready

## Operation
- Input pass: a registered skid stage. s_axis_tready is a register output; there is no combinational path from m_axis_tready.
- Pipeline enable: ce = !m_axis_tvalid || m_axis_tready. The whole pipeline, including the skid output, advances only when ce=1. Valid bits travel with the data.
- P1: register a, b, id, last, valid.
- P2: product = a*b, signed, ADW+BDW bits, sign-extended to AW.
- P3, accumulate on a valid beat:
  - sum = (first[id] ? 0 : acc[id]) + product, wrapping modulo 2^AW.
  - If last: forward sum to the output stage and set first[id]=1.
  - Otherwise: write acc[id]=sum and clear first[id].
  - Read and write of acc[id] happen in the same stage, so back-to-back beats on one channel need no forwarding.
- Output stage: shifted = sum >>> OSHIFT, then reduced to ODW bits per Configuration. Loads m_axis_tdata, m_axis_tid and m_axis_tuser, and sets m_axis_tvalid.
- Beat with tid ≥ NCH: accepted, then discarded at P1 (valid cleared). No state change, no output.
- A one-beat frame (tlast on a channel's first beat) outputs the scaled a*b.
- Channels interleave arbitrarily. A frame on one channel never affects another.

## Timing
- Reset (rst_n=0 at an edge) applies these values after that edge:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, m_axis_tuser=0.
  - s_axis_tready=0; it rises to 1 on the first edge with rst_n=1.
  - All pipeline valids cleared; all first[]=1; acc[] contents don't-care.
- Reset mid-frame discards partial sums and in-flight results. No output is produced for interrupted frames.
- Latency: tlast beat accepted at edge N, with no backpressure → m_axis_tvalid=1 after edge N+4.
- Throughput: one beat per cycle sustained on any channel mix, while m_axis_tready=1.
- Output holds: m_axis_tdata, m_axis_tid and m_axis_tuser stay stable while m_axis_tvalid=1 and m_axis_tready=0. The pipeline stalls and s_axis_tready falls on the following edge once the skid slot fills. No beat is lost or duplicated.
- When m_axis_tvalid and m_axis_tready are both 1 and a new result is ready in the same cycle, the new result replaces the old with no bubble.

## Configuration
- MACC_MULTI_SATURATE_EN defined:
  - Round half-up: add 1<<(OSHIFT−1) before the shift when OSHIFT>0.
  - Saturate to [−2^(ODW−1), 2^(ODW−1)−1].
  - m_axis_tuser=1 when clamping occurred.
- Undefined: floor shift, truncate to the low ODW bits (wrap), m_axis_tuser tied 0.

## Structure
- Shared package macc_pkg holds:
  - product/accumulator width helper functions
  - the round/saturate function (ODW, OSHIFT as arguments)
  - the elaboration width checks
- One sub-module, macc_multi_core: P1–P3 plus the acc[]/first[] register bank with a ce input.
- Top level holds the skid stage, the output register and the rounding logic.

## Test plan
- Defaults, no macro, ch0: (a,b) = (2,3),(4,5),(−1,7) with tlast on the third beat, OSHIFT=0, ODW=48, AW=48 → one output, tdata=19, tid=0, tvalid 4 cycles after the tlast handshake.
- Interleave ch0/ch1 beats (ch0: 1×1, 2×2 last; ch1: 10×10, 3×3 last) → outputs tid0=5 then tid1=109, no cross-talk.
- Hold m_axis_tready=0 for 10 cycles during a 16-beat stream → output held stable, s_axis_tready drops, all frame sums correct once released.
- With MACC_MULTI_SATURATE_EN, OSHIFT=4, ODW=8: frame sum 0x7FF0 → tdata=127, tuser=1. Sum 24 → tdata=2 (rounds 1.5 up), tuser=0.
- tid=NCH beat with tlast → no output, all other channels unaffected.
- Assert rst_n=0 mid-frame on ch2, then send 3×3 with tlast on ch2 → output 9 (partial sum discarded). All outputs 0 during reset.
